// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall sequencer.
//   state_t : sequencer state (RUN, MEM_WAIT, HALT)
//   REG_ZERO: architectural x0, never a real dependency
//   ctrl_t  : hold/flush/redirect bundle driven into the stage registers
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic hold_pc;
        logic hold_ifid;
        logic hold_idex;
        logic hold_exmem;
        logic hold_memwb;
        logic flush_ifid;
        logic flush_idex;
        logic flush_memwb;
        logic pc_redirect;
    } ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bus.
//   master: pipeline side, drives ID/EX/MEM status, receives hold/flush/debug
//   slave : hazard controller side
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             hold_pc;
    logic             hold_ifid;
    logic             hold_idex;
    logic             hold_exmem;
    logic             hold_memwb;
    logic             flush_ifid;
    logic             flush_idex;
    logic             flush_memwb;
    logic             pc_redirect;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_req, mem_ready,
        input  hold_pc, hold_ifid, hold_idex, hold_exmem, hold_memwb,
               flush_ifid, flush_idex, flush_memwb, pc_redirect, mem_err,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, mem_req, mem_ready,
        output hold_pc, hold_ifid, hold_idex, hold_exmem, hold_memwb,
               flush_ifid, flush_idex, flush_memwb, pc_redirect, mem_err,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter: counts cycles with inc=1, sticks at all-ones.
//   clk, rst (sync, active-high), inc -> count[CNT_W-1:0]
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of pipe_hazard_ctrl_if (hazard inputs in,
//              hold/flush/redirect controls, mem_err and debug counters out)
// Controls are Mealy: halt > memory wait > taken branch > load-use.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              err_set;
    logic              mem_wait, load_use;
    ctrl_t             ctrl;

    assign mem_wait = bus.mem_req & ~bus.mem_ready;
    assign load_use = bus.ex_mem_read & (bus.ex_rd != REG_ZERO) &
                      ((bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                       (bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            bus.mem_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_nxt;
            if (err_set)
                bus.mem_err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        err_set   = 1'b0;
        case (state)
            RUN: begin
                if (mem_wait) begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else if (mem_wait && (wait_cnt == WAIT_W'(WAIT_MAX))) begin
                    state_nxt = HALT;
                    err_set   = 1'b1;
                end else if (wait_cnt != WAIT_W'(WAIT_MAX)) begin
                    // capped so a dropped mem_req cannot run past the compare
                    wait_nxt  = wait_cnt + 1'b1;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        ctrl = '0;
        if (rst) begin
            ctrl = '0;
        end else if (state == HALT) begin
            ctrl.hold_pc     = 1'b1;
            ctrl.hold_ifid   = 1'b1;
            ctrl.hold_idex   = 1'b1;
            ctrl.hold_exmem  = 1'b1;
            ctrl.hold_memwb  = 1'b1;
            ctrl.flush_memwb = 1'b1;
        end else if (mem_wait) begin
            // freeze everything upstream of MEM; WB takes a bubble
            ctrl.hold_pc     = 1'b1;
            ctrl.hold_ifid   = 1'b1;
            ctrl.hold_idex   = 1'b1;
            ctrl.hold_exmem  = 1'b1;
            ctrl.flush_memwb = 1'b1;
        end else if (bus.ex_branch_taken) begin
            // a concurrent load-use belongs to a wrong-path instruction
            ctrl.pc_redirect = 1'b1;
            ctrl.flush_ifid  = 1'b1;
            ctrl.flush_idex  = 1'b1;
        end else if (load_use) begin
            ctrl.hold_pc     = 1'b1;
            ctrl.hold_ifid   = 1'b1;
            ctrl.flush_idex  = 1'b1;
        end
    end

    assign bus.hold_pc     = ctrl.hold_pc;
    assign bus.hold_ifid   = ctrl.hold_ifid;
    assign bus.hold_idex   = ctrl.hold_idex;
    assign bus.hold_exmem  = ctrl.hold_exmem;
    assign bus.hold_memwb  = ctrl.hold_memwb;
    assign bus.flush_ifid  = ctrl.flush_ifid;
    assign bus.flush_idex  = ctrl.flush_idex;
    assign bus.flush_memwb = ctrl.flush_memwb;
    assign bus.pc_redirect = ctrl.pc_redirect;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ctrl.hold_pc),
        .count (bus.stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (ctrl.flush_ifid | ctrl.flush_idex),
        .count (bus.flush_cnt)
    );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (WAIT_MAX=4, CNT_W=4).
// Reference model: halted flag, count of wait cycles so far, integer
// counters clamped at 15, outputs from the priority rules.
module tb_pipe_hazard_ctrl;
    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 4;
    localparam int CMAX     = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus();

    pipe_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    bit m_halt = 0;
    int m_wait = 0;
    bit m_err  = 0;
    int m_stall = 0;
    int m_flush = 0;

    logic [17:0] got, exp;

    function automatic logic [17:0] obs();
        return {bus.hold_pc, bus.hold_ifid, bus.hold_idex, bus.hold_exmem,
                bus.hold_memwb, bus.flush_ifid, bus.flush_idex,
                bus.flush_memwb, bus.pc_redirect, bus.mem_err,
                bus.stall_cnt, bus.flush_cnt};
    endfunction

    function automatic logic [17:0] model_out();
        logic hp, hi, hd, he, hm, fi, fd, fm, pr, lu, mw;
        {hp, hi, hd, he, hm, fi, fd, fm, pr} = '0;
        lu = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
             ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
              (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
        mw = bus.mem_req && !bus.mem_ready;
        if (rst) begin
        end else if (m_halt) begin
            {hp, hi, hd, he, hm, fm} = 6'b111111;
        end else if (mw) begin
            {hp, hi, hd, he, fm} = 5'b11111;
        end else if (bus.ex_branch_taken) begin
            {pr, fi, fd} = 3'b111;
        end else if (lu) begin
            {hp, hi, fd} = 3'b111;
        end
        return {hp, hi, hd, he, hm, fi, fd, fm, pr, m_err,
                4'(m_stall), 4'(m_flush)};
    endfunction

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic mrd, input logic br,
                          input logic mreq, input logic mrdy);
        bus.id_rs1 = rs1;  bus.id_rs2 = rs2;
        bus.id_use_rs1 = u1; bus.id_use_rs2 = u2;
        bus.ex_rd = rd; bus.ex_mem_read = mrd; bus.ex_branch_taken = br;
        bus.mem_req = mreq; bus.mem_ready = mrdy;
    endtask

    task automatic set_idle();
        set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // advance one clock edge and step the reference model with it
    task automatic tick();
        logic [17:0] e;
        logic mw;
        e  = model_out();
        mw = bus.mem_req && !bus.mem_ready;
        @(posedge clk);
        if (rst) begin
            m_halt = 0; m_wait = 0; m_err = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (e[17] && m_stall < CMAX) m_stall++;
            if ((e[12] || e[11]) && m_flush < CMAX) m_flush++;
            if (!m_halt) begin
                if (m_wait == 0) begin
                    if (mw) m_wait = 1;
                end else if (bus.mem_ready) begin
                    m_wait = 0;
                end else if (mw && m_wait == WAIT_MAX) begin
                    m_halt = 1;
                    m_err  = 1;
                end else begin
                    m_wait++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_in(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            got = obs(); exp = model_out(); checks++;
            if (got !== exp || got !== 18'd0) begin
                errors++;
                $display("FAIL reset cyc %0d got %b exp %b", i, got, exp);
            end
            tick();
        end
        rst = 1'b0;
        set_idle();
    endtask

    task automatic test_load_use();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: set_in(5'd5, 5'd7, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
                1: set_in(5'd5, 5'd7, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
                2: set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
                default: set_in(5'd3, 5'd6, 1'b0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
            endcase
            #1;
            got = obs(); exp = model_out(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL load_use cyc %0d got %b exp %b", i, got, exp);
            end
            tick();
        end
        set_idle();
        #1;
        got = obs(); checks++;
        if (got !== {14'd0, 4'd2, 4'd2}) begin
            errors++;
            $display("FAIL load_use_counts got %b exp %b", got, {14'd0, 4'd2, 4'd2});
        end
    endtask

    task automatic test_branch_load_use();
        do_reset();
        set_in(5'd5, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        #1;
        got = obs(); checks++;
        if (got !== {9'b000001101, 9'd0}) begin
            errors++;
            $display("FAIL branch_lu got %b exp %b", got, {9'b000001101, 9'd0});
        end
        tick();
        set_idle();
        #1;
        got = obs(); checks++;
        if (got !== {14'd0, 4'd0, 4'd1}) begin
            errors++;
            $display("FAIL branch_lu_counts got %b exp %b", got, {14'd0, 4'd0, 4'd1});
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, i >= 3);
            #1;
            got = obs(); exp = model_out(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL mem_wait cyc %0d got %b exp %b", i, got, exp);
            end
            tick();
        end
        set_idle();
        #1;
        got = obs(); checks++;
        if (got !== {14'd0, 4'd3, 4'd0}) begin
            errors++;
            $display("FAIL mem_wait_counts got %b exp %b", got, {14'd0, 4'd3, 4'd0});
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_in(5'd5, 5'd2, 1'b1, 1'b0, 5'd5, 1'b1, i == 7, 1'b1, i == 7);
            #1;
            got = obs(); exp = model_out(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL timeout cyc %0d got %b exp %b", i, got, exp);
            end
            tick();
        end
        // halted: holds and error must survive any input pattern
        set_idle();
        #1;
        got = obs(); checks++;
        if (got[17:8] !== 10'b1111100101) begin
            errors++;
            $display("FAIL halt_hold got %b exp 1111100101", got[17:8]);
        end
        rst = 1'b1;
        #1;
        got = obs(); exp = model_out(); checks++;
        if (got[17:9] !== 9'd0 || got !== exp) begin
            errors++;
            $display("FAIL rst_in_halt got %b exp %b", got, exp);
        end
        tick();
        rst = 1'b0;
        #1;
        got = obs(); checks++;
        if (got !== 18'd0) begin
            errors++;
            $display("FAIL post_halt_reset got %b exp 0", got);
        end
    endtask

    task automatic test_branch_during_wait();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, i < 3, 1'b1, i >= 2);
            #1;
            got = obs(); exp = model_out(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL branch_wait cyc %0d got %b exp %b", i, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 22; i++) begin
            set_in(5'd9, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
            #1;
            got = obs(); exp = model_out(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL saturation cyc %0d got %b exp %b", i, got, exp);
            end
            tick();
        end
        #1;
        checks++;
        if (bus.stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL stall_sat got %0d exp 15", bus.stall_cnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                   1'($urandom), ($urandom_range(0, 3) == 0),
                   1'($urandom), ($urandom_range(0, 2) != 0));
            if (m_wait > 0 && !m_halt) bus.mem_req = 1'b1;
            #1;
            got = obs(); exp = model_out(); checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random cyc %0d got %b exp %b", i, got, exp);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        set_idle();
        test_reset();
        test_load_use();
        test_branch_load_use();
        test_mem_wait();
        test_timeout();
        test_branch_during_wait();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
